// File: rtl/ex_stage.sv
// ex_stage: execute stage with ALU, HI/LO, single-cycle multiplier and 32-step restoring divider.
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic [4:0]  w_reg_addr_i,
    input  logic        wd_i,
    output logic [4:0]  w_reg_addr_o,
    output logic        wd_o,
    output logic [31:0] w_data_o,
    output logic        stall_req
);
    localparam logic [7:0] OP_ADDU = 8'h01, OP_SUBU = 8'h02, OP_AND = 8'h03, OP_OR = 8'h04,
                           OP_XOR = 8'h05, OP_NOR = 8'h06, OP_SLT = 8'h07, OP_SLTU = 8'h08,
                           OP_SLL = 8'h09, OP_SRL = 8'h0A, OP_SRA = 8'h0B, OP_DIV = 8'h20,
                           OP_DIVU = 8'h21, OP_MFHI = 8'h22, OP_MFLO = 8'h23, OP_MULT = 8'h24,
                           OP_MULTU = 8'h25;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [31:0] hi, lo, dvd, dsr, rem, res, sra;
    logic [5:0]  cnt;
    logic        q_neg, r_neg, is_div, is_sdiv, is_mul, sgn_mul, stall;
    logic [63:0] prod;
    logic [32:0] trial;

    assign is_div  = aluop_i == OP_DIV || aluop_i == OP_DIVU;
    assign is_sdiv = aluop_i == OP_DIV;
    assign is_mul  = aluop_i == OP_MULT || aluop_i == OP_MULTU;
    assign sgn_mul = aluop_i == OP_MULT;
    // Sign-extending to 64 bits makes the low 64 bits of the product correct for signed operands.
    assign prod    = {{32{sgn_mul & rs_data_i[31]}}, rs_data_i} * {{32{sgn_mul & rt_data_i[31]}}, rt_data_i};
    assign trial   = {rem, dvd[31]} - {1'b0, dsr};
    assign sra     = $unsigned($signed(rt_data_i) >>> rs_data_i[4:0]);
    assign stall   = (state == IDLE && is_div) || state == BUSY;

    always_comb begin
        res = '0;
        case (aluop_i)
            OP_ADDU: res = rs_data_i + rt_data_i;
            OP_SUBU: res = rs_data_i - rt_data_i;
            OP_AND:  res = rs_data_i & rt_data_i;
            OP_OR:   res = rs_data_i | rt_data_i;
            OP_XOR:  res = rs_data_i ^ rt_data_i;
            OP_NOR:  res = ~(rs_data_i | rt_data_i);
            OP_SLT:  res = {31'b0, $signed(rs_data_i) < $signed(rt_data_i)};
            OP_SLTU: res = {31'b0, rs_data_i < rt_data_i};
            OP_SLL:  res = rt_data_i << rs_data_i[4:0];
            OP_SRL:  res = rt_data_i >> rs_data_i[4:0];
            OP_SRA:  res = sra;
            OP_MFHI: res = hi;
            OP_MFLO: res = lo;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hi    <= '0;
            lo    <= '0;
            dvd   <= '0;
            dsr   <= '0;
            rem   <= '0;
            cnt   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_div && rt_data_i != '0) begin
                        dvd   <= (is_sdiv && rs_data_i[31]) ? -rs_data_i : rs_data_i;
                        dsr   <= (is_sdiv && rt_data_i[31]) ? -rt_data_i : rt_data_i;
                        rem   <= '0;
                        cnt   <= '0;
                        q_neg <= is_sdiv && (rs_data_i[31] ^ rt_data_i[31]);
                        r_neg <= is_sdiv && rs_data_i[31];
                        state <= BUSY;
                    end else if (is_div) begin
                        dvd   <= '1;
                        rem   <= rs_data_i;
                        q_neg <= 1'b0;
                        r_neg <= 1'b0;
                        state <= DONE;
                    end else if (is_mul) begin
                        {hi, lo} <= prod;
                    end
                end
                BUSY: begin
                    rem   <= trial[32] ? {rem[30:0], dvd[31]} : trial[31:0];
                    dvd   <= {dvd[30:0], ~trial[32]};
                    cnt   <= cnt + 6'd1;
                    state <= (cnt == 6'(DIV_CYCLES - 1)) ? DONE : BUSY;
                end
                DONE: begin
                    lo    <= q_neg ? -dvd : dvd;
                    hi    <= r_neg ? -rem : rem;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign w_data_o     = rst ? '0 : res;
    assign w_reg_addr_o = rst ? '0 : w_reg_addr_i;
    assign wd_o         = rst ? 1'b0 : wd_i & ~stall;
    assign stall_req    = rst ? 1'b0 : stall;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors push expectations; a negedge monitor pops and compares.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop;
    logic [31:0] rs, rt;
    logic [4:0]  addr;
    logic        wd;
    logic [4:0]  addr_o;
    logic        wd_o, stall;
    logic [31:0] data_o;

    typedef struct {
        string       n;
        logic [31:0] d;
        logic        w;
        logic [4:0]  a;
        logic        s;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop), .rs_data_i(rs), .rt_data_i(rt),
        .w_reg_addr_i(addr), .wd_i(wd), .w_reg_addr_o(addr_o), .wd_o(wd_o),
        .w_data_o(data_o), .stall_req(stall)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (data_o !== e.d || wd_o !== e.w || addr_o !== e.a || stall !== e.s) begin
                fails++;
                $display("FAIL %s: got data=%h wd=%b addr=%0d stall=%b, want data=%h wd=%b addr=%0d stall=%b",
                         e.n, data_o, wd_o, addr_o, stall, e.d, e.w, e.a, e.s);
            end
        end
    end

    task automatic cyc(input string n, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] ad, input logic w, input logic [31:0] ed, input logic ew,
                       input logic [4:0] ea, input logic es);
        exp_t e;
        aluop = op; rs = a; rt = b; addr = ad; wd = w;
        e.n = n; e.d = ed; e.w = ew; e.a = ea; e.s = es;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; aluop = '0; rs = '0; rt = '0; addr = '0; wd = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset_force", 8'h01, 32'h1, 32'h1, 5'd3, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0);
        cyc("reset_force2", 8'h20, 32'h9, 32'h2, 5'd7, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        cyc("reset_hi", 8'h22, 32'h0, 32'h0, 5'd2, 1'b1, 32'h0, 1'b1, 5'd2, 1'b0);
        cyc("reset_lo", 8'h23, 32'h0, 32'h0, 5'd2, 1'b1, 32'h0, 1'b1, 5'd2, 1'b0);
        cyc("addu_wrap", 8'h01, 32'hFFFFFFFF, 32'h2, 5'd5, 1'b1, 32'h1, 1'b1, 5'd5, 1'b0);
        cyc("subu_wrap", 8'h02, 32'h0, 32'h1, 5'd6, 1'b1, 32'hFFFFFFFF, 1'b1, 5'd6, 1'b0);
        cyc("and", 8'h03, 32'hF0F000FF, 32'h0FF00F0F, 5'd7, 1'b1, 32'h00F0000F, 1'b1, 5'd7, 1'b0);
        cyc("or", 8'h04, 32'hF0F000FF, 32'h0FF00F0F, 5'd8, 1'b1, 32'hFFF00FFF, 1'b1, 5'd8, 1'b0);
        cyc("xor", 8'h05, 32'hF0F000FF, 32'h0FF00F0F, 5'd9, 1'b1, 32'hFF000FF0, 1'b1, 5'd9, 1'b0);
        cyc("nor", 8'h06, 32'hF0F000FF, 32'h0FF00F0F, 5'd10, 1'b0, 32'h000FF000, 1'b0, 5'd10, 1'b0);
        cyc("slt", 8'h07, 32'hFFFFFFFE, 32'h1, 5'd11, 1'b1, 32'h1, 1'b1, 5'd11, 1'b0);
        cyc("sltu", 8'h08, 32'hFFFFFFFE, 32'h1, 5'd11, 1'b1, 32'h0, 1'b1, 5'd11, 1'b0);
        cyc("sra", 8'h0B, 32'h4, 32'h80000000, 5'd12, 1'b1, 32'hF8000000, 1'b1, 5'd12, 1'b0);
        cyc("srl", 8'h0A, 32'h4, 32'h80000000, 5'd12, 1'b1, 32'h08000000, 1'b1, 5'd12, 1'b0);
        cyc("sll31", 8'h09, 32'd31, 32'h1, 5'd13, 1'b1, 32'h80000000, 1'b1, 5'd13, 1'b0);
        cyc("sll_amt5", 8'h09, 32'h21, 32'h1, 5'd13, 1'b1, 32'h2, 1'b1, 5'd13, 1'b0);
        cyc("nop_unknown", 8'h3F, 32'h5, 32'h6, 5'd14, 1'b1, 32'h0, 1'b1, 5'd14, 1'b0);
        cyc("mult", 8'h24, 32'hFFFFFFFF, 32'h2, 5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
        cyc("mult_hi", 8'h22, 32'h0, 32'h0, 5'd1, 1'b1, 32'hFFFFFFFF, 1'b1, 5'd1, 1'b0);
        cyc("mult_lo", 8'h23, 32'h0, 32'h0, 5'd1, 1'b1, 32'hFFFFFFFE, 1'b1, 5'd1, 1'b0);
        cyc("multu", 8'h25, 32'hFFFFFFFF, 32'h2, 5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
        cyc("multu_hi", 8'h22, 32'h0, 32'h0, 5'd1, 1'b1, 32'h1, 1'b1, 5'd1, 1'b0);
        cyc("multu_lo", 8'h23, 32'h0, 32'h0, 5'd1, 1'b1, 32'hFFFFFFFE, 1'b1, 5'd1, 1'b0);
        for (int i = 0; i < 33; i++)
            cyc("div_stall", 8'h20, 32'hFFFFFFF9, 32'h2, 5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
        cyc("div_done", 8'h20, 32'hFFFFFFF9, 32'h2, 5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
        cyc("div_lo", 8'h23, 32'h0, 32'h0, 5'd4, 1'b1, 32'hFFFFFFFD, 1'b1, 5'd4, 1'b0);
        cyc("div_hi", 8'h22, 32'h0, 32'h0, 5'd4, 1'b1, 32'hFFFFFFFF, 1'b1, 5'd4, 1'b0);
        for (int i = 0; i < 33; i++)
            cyc("divu_stall_wd_mask", 8'h21, 32'd100, 32'd7, 5'd3, 1'b1, 32'h0, 1'b0, 5'd3, 1'b1);
        cyc("divu_done", 8'h21, 32'd100, 32'd7, 5'd3, 1'b1, 32'h0, 1'b1, 5'd3, 1'b0);
        cyc("divu_lo", 8'h23, 32'h0, 32'h0, 5'd4, 1'b1, 32'd14, 1'b1, 5'd4, 1'b0);
        cyc("divu_hi", 8'h22, 32'h0, 32'h0, 5'd4, 1'b1, 32'd2, 1'b1, 5'd4, 1'b0);
        cyc("div0_stall", 8'h20, 32'd5, 32'd0, 5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
        cyc("div0_done", 8'h20, 32'd5, 32'd0, 5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
        cyc("div0_lo", 8'h23, 32'h0, 32'h0, 5'd4, 1'b1, 32'hFFFFFFFF, 1'b1, 5'd4, 1'b0);
        cyc("div0_hi", 8'h22, 32'h0, 32'h0, 5'd4, 1'b1, 32'd5, 1'b1, 5'd4, 1'b0);
        for (int i = 0; i < 11; i++)
            cyc("div_pre_rst", 8'h20, 32'd100, 32'd7, 5'd0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
        rst = 1'b1;
        cyc("rst_mid_div", 8'h20, 32'd100, 32'd7, 5'd9, 1'b1, 32'h0, 1'b0, 5'd0, 1'b0);
        rst = 1'b0;
        cyc("rst_mid_hi", 8'h22, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0, 1'b1, 5'd4, 1'b0);
        cyc("rst_mid_lo", 8'h23, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0, 1'b1, 5'd4, 1'b0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS-style core.
- Consumes the outputs of the ID/EX pipeline register and computes the ALU result; drives the EX/MEM register inputs.
- Owns the HI/LO registers, a single-cycle multiplier and a 32-iteration sequential divider.
- While a divide is in progress it raises stall_req, so the pipeline controller freezes IF/ID/ID-EX.

Parameters:
DIV_CYCLES, 32, divider iteration count (fixed at 32 for 32-bit operands)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
aluop_i  input  8  operation code from ID/EX
rs_data_i  input  32  operand A (rs)
rt_data_i  input  32  operand B (rt)
w_reg_addr_i  input  5  destination GPR
wd_i  input  1  GPR write enable
w_reg_addr_o  output  5  destination GPR to EX/MEM
wd_o  output  1  GPR write enable to EX/MEM
w_data_o  output  32  result to EX/MEM
stall_req  output  1  freeze upstream stages and ID/EX this cycle

Behaviour:
- Reset (rst=1 at a clk edge):
  - HI, LO, divider state, counter and operand registers clear to 0; FSM goes to IDLE.
  - While rst=1 all outputs are forced to 0 (combinational override).
  - Reset mid-divide abandons the divide; HI/LO stay 0.
- aluop encoding, all other codes are NOP (result 0):
  - 00 NOP; 01 ADDU; 02 SUBU; 03 AND; 04 OR; 05 XOR; 06 NOR.
  - 07 SLT signed; 08 SLTU; 09 SLL; 0A SRL; 0B SRA.
  - 20 DIV; 21 DIVU; 22 MFHI; 23 MFLO; 24 MULT; 25 MULTU.
- Shifts: value rt_data_i, amount rs_data_i[4:0].
- ADDU/SUBU wrap modulo 2^32; there is no overflow detection.
- Combinational path: w_data_o, w_reg_addr_o = w_reg_addr_i, wd_o = wd_i & ~stall_req. Zero latency.
- MFHI/MFLO return the HI/LO register value as of the current cycle; there is no internal bypass.
- MULT/MULTU:
  - Full 64-bit product, signed or unsigned.
  - {HI,LO} are written at the clk edge ending the cycle; no stall.
  - w_data_o=0.
- Divider FSM:
  - IDLE:
    - If aluop is DIV/DIVU and rt≠0: latch |rs|, |rt| (raw values for DIVU) and the quotient/remainder signs. stall_req=1, counter←0, next state BUSY.
    - If aluop is DIV/DIVU and rt=0: stall_req=1, next state DONE, result preset to LO=FFFFFFFF, HI=rs.
    - Otherwise stall_req=0.
  - BUSY:
    - One restoring shift-subtract iteration per cycle; stall_req=1; counter++.
    - When counter=DIV_CYCLES-1, next state DONE.
  - DONE:
    - stall_req=0.
    - Signs are applied: quotient negative if operand signs differ; remainder takes the sign of rs.
    - LO←quotient, HI←remainder at the clock edge ending this cycle; next state IDLE.
    - The same DIV op still present on the inputs in DONE must not restart the divider.
- Latency (rt≠0): DIV occupies EX for 34 cycles, stall_req high for 33 of them (IDLE cycle + 32 BUSY).
- Divide by zero: stall_req high for 1 cycle, DIV occupies EX for 2 cycles.
- Upstream must hold the inputs stable while stall_req=1.
- Input changes during BUSY are ignored; the divider uses its latched operands.
- wd_o is forced 0 while stall_req=1, so EX/MEM only sees a bubble.
- Decoder guarantees wd_i=0 for DIV/MULT/NOP. The block still drives wd_o=wd_i (masked) and does not override it.

Test Plan:
- ADDU rs=0xFFFFFFFF, rt=2, wd_i=1, addr=5 -> same cycle w_data_o=0x00000001, wd_o=1, w_reg_addr_o=5, stall_req=0.
- SLT rs=0xFFFFFFFE (-2), rt=1 -> w_data_o=1; SLTU with the same operands -> 0.
- SRA rt=0x80000000, rs=4 -> w_data_o=0xF8000000; SLL rt=1, rs=31 -> w_data_o=0x80000000.
- MULT rs=0xFFFFFFFF, rt=2, then MFHI, then MFLO -> HI=0xFFFFFFFF, LO=0xFFFFFFFE, stall_req never asserted.
- DIV rs=0xFFFFFFF9 (-7), rt=2, held while stalled -> stall_req high for exactly 33 cycles, wd_o=0 throughout. Then MFLO returns 0xFFFFFFFD and MFHI returns 0xFFFFFFFF.
  - DIVU 100/7 -> LO=14, HI=2.
- DIV rs=5, rt=0 -> stall_req high for 1 cycle, then LO=0xFFFFFFFF, HI=5.
  - Separately: assert rst at BUSY cycle 10 -> next cycle stall_req=0, FSM in IDLE, HI=LO=0.
